// File: rtl/dec1s_seq.sv
// AES inverse round-word unit: rd = rs1 ^ InvSubWord(rs2) [^ InvMixColumn], LANES inverse S-boxes per cycle.
// Latency 4/LANES cycles from accept to out_valid; rd held under unbounded out_ready backpressure, one idle bubble between ops.
module dec1s_seq #(
    parameter int LANES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        mix,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] rd
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("dec1s_seq: LANES must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  idx;
    logic [31:0] acc, acc_nxt;
    logic [31:0] src;
    logic        mix_q;
    logic        last;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int k = 1; k < 8; k++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] b;
        b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [31:0] rotl_bytes(input logic [31:0] t, input logic [1:0] n);
        logic [31:0] r;
        case (n)
            2'd0:    r = t;
            2'd1:    r = {t[23:0], t[31:24]};
            2'd2:    r = {t[15:0], t[31:16]};
            default: r = {t[7:0],  t[31:8]};
        endcase
        return r;
    endfunction

    always_comb begin
        logic [1:0]  bi;
        logic [7:0]  x;
        logic [31:0] t;
        bi      = 2'd0;
        x       = 8'h00;
        t       = 32'h0;
        acc_nxt = acc;
        for (int l = 0; l < LANES; l++) begin
            bi = idx + 2'(l);
            x  = inv_sbox(src[8*bi +: 8]);
            t  = mix_q ? {gmul(x, 8'h0B), gmul(x, 8'h0D), gmul(x, 8'h09), gmul(x, 8'h0E)}
                       : {24'h0, x};
            acc_nxt = acc_nxt ^ rotl_bytes(t, bi);
        end
    end

    assign last = (idx == 2'(4 - LANES));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= 2'd0;
            acc   <= 32'h0;
            src   <= 32'h0;
            mix_q <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            idx   <= 2'd0;
            acc   <= rs1;
            src   <= rs2;
            mix_q <= mix;
        end else if (state == BUSY) begin
            idx   <= idx + 2'(LANES);
            acc   <= acc_nxt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign rd        = acc;

endmodule

// File: tb/tb_dec1s_seq.sv
// Bench for dec1s_seq: one instance per legal LANES value, driven one at a time against a queue of expected results.
module tb_dec1s_seq;

    logic        clk;
    logic        rst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        mix;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] rd        [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int cur    = 0;
    bit seen   = 0;

    typedef struct {
        logic [31:0] rd;
        int          lat;
        int          acc_cyc;
    } exp_t;
    exp_t q[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dec1s_seq #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .rs1       (rs1),
            .rs2       (rs2),
            .mix       (mix),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .rd        (rd[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (dut %0d, t=%0t)", name, act, exp, cur, $time);
        end
    endtask

    // Monitor: latency on the rising out_valid, result on the output handshake.
    always @(negedge clk) begin
        if (out_valid[cur] && !seen) begin
            seen = 1;
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                chk("latency", 32'(cyc - q[0].acc_cyc), 32'(q[0].lat));
            end
        end
        if (out_valid[cur] && out_ready[cur] && q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rd", rd[cur], e.rd);
            seen = 0;
        end
    end

    task automatic send(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic m, input logic [31:0] exp);
        int n;
        exp_t e;
        @(negedge clk);
        rs1 = a;
        rs2 = b;
        mix = m;
        in_valid[d] = 1'b1;
        n = 0;
        while (!in_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        e.rd      = exp;
        e.lat     = 4 >> d;
        e.acc_cyc = cyc;
        q.push_back(e);
        rs1 = ~a;
        rs2 = b ^ 32'h5A5A5A5A;
        mix = ~m;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    logic [31:0] v_rs1 [6] = '{32'h00000000, 32'hFFFFFFFF, 32'h00000000,
                               32'h00000000, 32'h12345678, 32'hA5A5A5A5};
    logic [31:0] v_rs2 [6] = '{32'h00000000, 32'h63636363, 32'h6532E319,
                               32'h00000000, 32'h6532E319, 32'h6532E319};
    logic        v_mix [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] v_exp [6] = '{32'h52525252, 32'hFFFFFFFF, 32'h455313DB,
                               32'h52525252, 32'hAE951BF6, 32'hE0F6B67E};

    initial begin
        int n;
        rst = 1'b1;
        rs1 = 32'h0;
        rs2 = 32'h0;
        mix = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            cur = d;
            chk("reset_rd", rd[d], 32'h0);
            chk("reset_out_valid", 32'(out_valid[d]), 32'd0);
            chk("reset_in_ready", 32'(in_ready[d]), 32'd1);
        end

        for (int d = 0; d < 3; d++) begin
            cur  = d;
            seen = 0;
            for (int i = 0; i < 6; i++) send(d, v_rs1[i], v_rs2[i], v_mix[i], v_exp[i]);
            drain();

            // Backpressure: result and handshake outputs must freeze, new requests ignored.
            out_ready[d] = 1'b0;
            send(d, 32'h0, 32'h6532E319, 1'b1, 32'h455313DB);
            n = 0;
            while (!out_valid[d] && n < 20) begin
                @(negedge clk);
                n++;
            end
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                chk("bp_rd", rd[d], 32'h455313DB);
                chk("bp_out_valid", 32'(out_valid[d]), 32'd1);
                chk("bp_in_ready", 32'(in_ready[d]), 32'd0);
                rs1 = 32'(k) * 32'h01010101;
                rs2 = 32'h11111111 << k;
                mix = k[0];
                in_valid[d] = k[0];
            end
            @(negedge clk);
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
            drain();
        end

        // Abort: reset two cycles into a LANES=1 operation (idx=2).
        cur  = 0;
        seen = 0;
        @(negedge clk);
        rs1 = 32'hDEADBEEF;
        rs2 = 32'h01234567;
        mix = 1'b1;
        chk("abort_pre_in_ready", 32'(in_ready[0]), 32'd1);
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready[0]), 32'd1);
        chk("abort_out_valid", 32'(out_valid[0]), 32'd0);
        chk("abort_rd", rd[0], 32'h0);
        repeat (6) @(negedge clk);
        chk("abort_no_result", 32'(out_valid[0]), 32'd0);

        send(0, 32'h0, 32'h00000000, 1'b0, 32'h52525252);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
